// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants and payload type for the RV32I ALU issue stage
//
// Purpose : ALU opcode encodings, major-opcode and funct7 constants,
//           skid-buffer state type and the issue payload struct.
// Ports   : none (package).

package rv32i_pkg;

   localparam int XLEN = 32;

   // ALU opcode = {funct7[5], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   // Major opcodes
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // funct7 values
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3 values that matter to decode
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } buf_state_t;

   typedef struct packed {
      logic [3:0]      opcode;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [4:0]      rd;
      logic            we;
      logic            illegal;
   } issue_payload_t;

endpackage

// File: rtl/rv32i_alu_decode.sv
// rtl/rv32i_alu_decode.sv - combinational RV32I ALU decoder and immediate generator
//
// Purpose : turns one raw instruction plus its PC and register read data
//           into an issue payload (ALU opcode, operands, writeback control).
// Ports   : i_instr     instruction word
//           i_pc        instruction PC (AUIPC operand)
//           i_rs1_data  register-file read data for rs1
//           i_rs2_data  register-file read data for rs2
//           o_rs1_addr  instr[19:15]
//           o_rs2_addr  instr[24:20]
//           o_payload   decoded payload

module rv32i_alu_decode
   import rv32i_pkg::*;
(
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output issue_payload_t  o_payload
);

   logic [6:0]      w_major;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [4:0]      w_rd;
   logic            w_is_shift;
   logic            w_legal;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_u;
   issue_payload_t  w_pl;

   assign w_major    = i_instr[6:0];
   assign w_rd       = i_instr[11:7];
   assign w_funct3   = i_instr[14:12];
   assign w_funct7   = i_instr[31:25];
   assign o_rs1_addr = i_instr[19:15];
   assign o_rs2_addr = i_instr[24:20];

   assign w_is_shift = (w_funct3 == F3_SLL) || (w_funct3 == F3_SR);
   assign w_imm_i    = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
   assign w_imm_u    = {i_instr[31:12], 12'b0};

   always_comb begin
      w_pl    = '0;
      w_legal = 1'b0;
      case (w_major)
         OPC_OP: begin
            w_legal   = (w_funct7 == F7_BASE) ||
                        ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
            w_pl.opcode = {w_funct7[5], w_funct3};
            w_pl.op1    = i_rs1_data;
            w_pl.op2    = w_is_shift ? {{(XLEN-5){1'b0}}, i_rs2_data[4:0]} : i_rs2_data;
         end
         OPC_OP_IMM: begin
            // Outside the shifts, instr[31:25] is immediate, not funct7.
            if (w_funct3 == F3_SLL)
               w_legal = (w_funct7 == F7_BASE);
            else if (w_funct3 == F3_SR)
               w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
            else
               w_legal = 1'b1;
            w_pl.opcode = {(w_funct3 == F3_SR) & w_funct7[5], w_funct3};
            w_pl.op1    = i_rs1_data;
            w_pl.op2    = w_is_shift ? {{(XLEN-5){1'b0}}, i_instr[24:20]} : w_imm_i;
         end
         OPC_LUI: begin
            w_legal     = 1'b1;
            w_pl.opcode = ALU_ADD;
            w_pl.op2    = w_imm_u;
         end
         OPC_AUIPC: begin
            w_legal     = 1'b1;
            w_pl.opcode = ALU_ADD;
            w_pl.op1    = i_pc;
            w_pl.op2    = w_imm_u;
         end
         default: w_legal = 1'b0;
      endcase

      if (w_legal) begin
         w_pl.rd      = w_rd;
         w_pl.we      = (w_rd != 5'd0);
         w_pl.illegal = 1'b0;
      end else begin
         // Illegal encodings still flow down the pipe as an inert ADD.
         w_pl         = '0;
         w_pl.illegal = 1'b1;
      end
   end

   assign o_payload = w_pl;

endmodule

// File: rtl/rv32i_alu_issue.sv
// rtl/rv32i_alu_issue.sv - RV32I decode/issue stage with 2-entry skid buffer
//
// Purpose : decodes OP/OP-IMM/LUI/AUIPC and issues ALU payloads to execute
//           through a 2-entry FIFO skid buffer with a registered upstream ready.
// Ports   : clk_in, reset_in (async, active-high), flush_in
//           instr_valid_in / instr_ready_out / instr_in / pc_in   upstream
//           rs1_addr_out, rs2_addr_out, rs1_data_in, rs2_data_in  regfile
//           issue_valid_out / issue_ready_in                      execute handshake
//           alu_opcode_out, op_1_out, op_2_out, rd_addr_out,
//           rd_we_out, illegal_out                                payload

module rv32i_alu_issue
   import rv32i_pkg::*;
(
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            flush_in,
   input  logic            instr_valid_in,
   output logic            instr_ready_out,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic [4:0]      rs1_addr_out,
   output logic [4:0]      rs2_addr_out,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   output logic            issue_valid_out,
   input  logic            issue_ready_in,
   output logic [3:0]      alu_opcode_out,
   output logic [XLEN-1:0] op_1_out,
   output logic [XLEN-1:0] op_2_out,
   output logic [4:0]      rd_addr_out,
   output logic            rd_we_out,
   output logic            illegal_out
);

   buf_state_t     r_state;
   buf_state_t     w_next_state;
   logic           r_ready;
   issue_payload_t r_head;   // entry presented to execute
   issue_payload_t r_skid;   // second entry, valid only in S_FULL
   issue_payload_t w_dec;
   logic           w_accept;
   logic           w_issue;
   logic           w_load_head_new;
   logic           w_load_head_skid;
   logic           w_load_skid;

   rv32i_alu_decode u_decode (
      .i_instr    (instr_in),
      .i_pc       (pc_in),
      .i_rs1_data (rs1_data_in),
      .i_rs2_data (rs2_data_in),
      .o_rs1_addr (rs1_addr_out),
      .o_rs2_addr (rs2_addr_out),
      .o_payload  (w_dec)
   );

   assign issue_valid_out = (r_state != S_EMPTY);
   assign w_accept        = instr_valid_in && r_ready;
   assign w_issue         = issue_valid_out && issue_ready_in;

   always_comb begin
      w_next_state     = r_state;
      w_load_head_new  = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush_in) begin
         w_next_state = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_next_state    = S_ONE;
                  w_load_head_new = 1'b1;
               end
            end
            S_ONE: begin
               case ({w_accept, w_issue})
                  2'b10: begin
                     w_next_state = S_FULL;
                     w_load_skid  = 1'b1;
                  end
                  2'b11: w_load_head_new = 1'b1;
                  2'b01: w_next_state    = S_EMPTY;
                  default: w_next_state  = S_ONE;
               endcase
            end
            S_FULL: begin
               // Ready is low in FULL, so no accept can coincide here.
               if (w_issue) begin
                  w_next_state     = S_ONE;
                  w_load_head_skid = 1'b1;
               end
            end
            default: w_next_state = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state <= S_EMPTY;
         r_ready <= 1'b1;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state != S_FULL);
         if (w_load_head_new)
            r_head <= w_dec;
         else if (w_load_head_skid)
            r_head <= r_skid;
         if (w_load_skid)
            r_skid <= w_dec;
      end
   end

   assign instr_ready_out = r_ready;
   assign alu_opcode_out  = r_head.opcode;
   assign op_1_out        = r_head.op1;
   assign op_2_out        = r_head.op2;
   assign rd_addr_out     = r_head.rd;
   assign rd_we_out       = r_head.we;
   assign illegal_out     = r_head.illegal;

endmodule

// File: doc/rv32i_alu_issue.md
# rv32i_alu_issue

Decode/issue stage driving the RV32I integer ALU's operand interface. It accepts raw instructions with PC, decodes OP, OP-IMM, LUI and AUIPC into a 4-bit ALU opcode, two 32-bit operands and writeback control, then presents them to the execute stage. A 2-entry skid buffer with valid/ready handshakes on both sides gives a registered upstream ready and one-instruction-per-cycle throughput.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk_in  input  1  clock; all state changes on rising edge.
- reset_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  synchronous discard of all buffered entries.
- instr_valid_in  input  1  upstream instruction valid.
- instr_ready_out  output  1  registered; high when a new instruction can be accepted.
- instr_in  input  32  raw instruction word.
- pc_in  input  32  instruction PC.
- rs1_addr_out, rs2_addr_out  output  5 each  combinational instr_in[19:15], [24:20], for register-file read.
- rs1_data_in, rs2_data_in  input  32 each  register-file read data, same cycle as instr_in.
- issue_valid_out  output  1  payload valid toward execute.
- issue_ready_in  input  1  execute accepts payload.
- alu_opcode_out  output  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- op_1_out, op_2_out  output  32 each  ALU operands.
- rd_addr_out  output  5  destination register.
- rd_we_out  output  1  writeback enable.
- illegal_out  output  1  unsupported or malformed encoding.

## Operation
- Accept: instr_valid_in && instr_ready_out at a rising edge; rs1/rs2 data captured in the same edge.
- OP (0110011): opcode = {funct7[5], funct3}; op1 = rs1 data; op2 = rs2 data, masked to bits [4:0] for SLL/SRL/SRA.
- OP-IMM (0010011): op2 = sign-extended imm[11:0]; opcode bit 3 = funct7[5] only for funct3 101, else 0; shifts use op2 = zero-extended shamt.
- LUI (0110111): op1 = 0, op2 = {instr[31:12], 12'b0}, ADD. AUIPC (0010111): op1 = pc_in, op2 same, ADD.
- Legal funct7: 0000000 always; 0100000 only with funct3 000 (OP only) or 101. SLLI requires funct7 0000000.
- Illegal: any other major opcode or funct7. Payload: ADD, operands 0, rd_we_out 0, illegal_out 1. Still issued, consumes a slot.
- rd_we_out = 0 when rd = x0.
- Buffer states: EMPTY, ONE, FULL. Accept without issue: EMPTY->ONE, ONE->FULL. Issue without accept: FULL->ONE, ONE->EMPTY. Both together: state unchanged. Strict FIFO order.
- instr_ready_out registered: 0 exactly when next state is FULL.
- flush_in: next state EMPTY, instr_ready_out 1; a same-cycle accept is discarded; flush wins.

## Timing
- Latency: accepted at edge N -> issue_valid_out high after edge N.
- Throughput: 1 per cycle with issue_ready_in held high.
- Payload stable while issue_valid_out && !issue_ready_in.
- Reset (any time, including mid-stream): state EMPTY, instr_ready_out 1, issue_valid_out 0, all payload outputs 0. Buffered entries lost.
- rs*_addr_out purely combinational; no hazard or forwarding logic here.

## Structure
- Package rv32i_pkg: ALU opcode localparams, major-opcode constants, funct7 constants, issue payload struct (opcode, op1, op2, rd, we, illegal).
- Sub-module rv32i_alu_decode: combinational decoder and immediate generator, one instance at the input. Skid buffer and FSM stay in the top.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: opcode 0000, op1 5, op2 7, rd 3, we 1.
- srai x5,x6,3 (0x40335293), rs1 data 0x80000000 -> opcode 1101, op1 0x80000000, op2 3, rd 5.
- sll with rs2 data 0x00000025 -> op2 0x00000005. lui x1,0x12345 (0x123450B7) -> op1 0, op2 0x12345000, ADD.
- Backpressure: hold issue_ready_in 0, offer 3 instructions -> 2 accepted, ready low after the 2nd; release -> issued in order 1, 2, then 3 accepted.
- Illegal: 0xFE0080B3 (funct7 1111111) and jal 0x0000006F -> illegal_out 1, rd_we_out 0, opcode 0000.
- Flush with FULL plus a simultaneous accept -> EMPTY next cycle, nothing issued. Assert reset_in mid-stream -> all outputs 0 immediately, ready 1.
